// File: rtl/lpm_tbl_access_ctrl.sv
// AXI4-Lite register front end for the 32 x 128-bit LPM route table.
// Stages entry data and an index, and issues one-cycle read/write strobes with an ack timeout.
module lpm_tbl_access_ctrl #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h0000_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h0000_003F,
  parameter int                            C_ACK_TIMEOUT      = 16
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            tbl_rd_req,
  output logic                            tbl_wr_req,
  output logic [4:0]                      tbl_rd_addr,
  output logic [4:0]                      tbl_wr_addr,
  output logic [127:0]                    tbl_wr_data,
  input  logic [127:0]                    tbl_rd_data,
  input  logic                            tbl_wr_ack,
  input  logic                            tbl_rd_ack
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int CW = (C_ACK_TIMEOUT < 2) ? 1 : $clog2(C_ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_ACK_TIMEOUT - 1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [3:0] R_ADDR = 4'd8, R_CMD = 4'd9, R_STAT = 4'd10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_e;

  state_e               state_q;
  logic [3:0][31:0]     wr_data_q, rd_data_q;
  logic [4:0]           addr_q;
  logic                 busy_q, done_q, timeout_q, err_q, cmd_rd_q;
  logic [CW-1:0]        cnt_q;
  logic                 rd_req_q, wr_req_q;
  logic                 awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q, rd_val;

  logic [AW-1:0] wr_off, rd_off;
  logic [3:0]    wr_idx, rd_idx;
  logic          wr_hit, rd_hit, wr_ro, wr_err, wr_hs, rd_hs, wr_ok, cmd_wr, cmd_ok;

  assign wr_off = S_AXI_AWADDR - C_BASEADDR;
  assign rd_off = S_AXI_ARADDR - C_BASEADDR;
  assign wr_idx = wr_off[5:2];
  assign rd_idx = rd_off[5:2];
  assign wr_hit = (S_AXI_AWADDR >= C_BASEADDR) && (S_AXI_AWADDR <= C_HIGHADDR) &&
                  (wr_off[AW-1:6] == '0) && (wr_idx <= R_STAT);
  assign rd_hit = (S_AXI_ARADDR >= C_BASEADDR) && (S_AXI_ARADDR <= C_HIGHADDR) &&
                  (rd_off[AW-1:6] == '0) && (rd_idx <= R_STAT);

  // Every writable register is frozen while a table access is in flight.
  assign wr_ro  = (wr_idx[3:2] == 2'b01) || (wr_idx == R_STAT);
  assign wr_err = !wr_hit || wr_ro || busy_q;
  assign wr_hs  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = arready_q && S_AXI_ARVALID;
  assign wr_ok  = wr_hs && !wr_err;
  assign cmd_wr = wr_ok && (wr_idx == R_CMD);
  assign cmd_ok = S_AXI_WDATA[0] ^ S_AXI_WDATA[1];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_WSTRB, wr_off[1:0], rd_off[1:0]};

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_idx)
        4'd0, 4'd1, 4'd2, 4'd3: rd_val = wr_data_q[rd_idx[1:0]];
        4'd4, 4'd5, 4'd6, 4'd7: rd_val = rd_data_q[rd_idx[1:0]];
        R_ADDR:                 rd_val = {27'd0, addr_q};
        R_STAT:                 rd_val = {28'd0, err_q, timeout_q, done_q, busy_q};
        default:                rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? SLVERR : OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_hit ? OKAY : SLVERR;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      if (wr_ok && (wr_idx[3:2] == 2'b00)) wr_data_q[wr_idx[1:0]] <= S_AXI_WDATA[31:0];
      if (wr_ok && (wr_idx == R_ADDR))     addr_q <= S_AXI_WDATA[4:0];
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      cmd_rd_q  <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_wr) begin
          if (cmd_ok) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            cmd_rd_q  <= S_AXI_WDATA[0];
            rd_req_q  <= S_AXI_WDATA[0];
            wr_req_q  <= S_AXI_WDATA[1];
            state_q   <= REQ;
          end else begin
            err_q <= 1'b1;
          end
        end
        REQ: begin
          cnt_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack for the other command type is not ours and is dropped.
          if (cmd_rd_q ? tbl_rd_ack : tbl_wr_ack) begin
            if (cmd_rd_q) rd_data_q <= tbl_rd_data;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign tbl_rd_req    = rd_req_q;
  assign tbl_wr_req    = wr_req_q;
  assign tbl_rd_addr   = addr_q;
  assign tbl_wr_addr   = addr_q;
  assign tbl_wr_data   = wr_data_q;
endmodule

// File: tb/tb_lpm_tbl_access_ctrl.sv
// Directed bench for lpm_tbl_access_ctrl: scoreboards for AXI responses and table strobes,
// plus a small registered-ack table model whose acks can be disabled.
module tb_lpm_tbl_access_ctrl;
  logic         AXI_ACLK = 1'b0, AXI_RESETN;
  logic [31:0]  S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic         tbl_rd_req, tbl_wr_req, tbl_wr_ack, tbl_rd_ack;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_wr_data, tbl_rd_data;

  always #5 AXI_ACLK = ~AXI_ACLK;

  lpm_tbl_access_ctrl dut (
    .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req), .tbl_rd_addr(tbl_rd_addr),
    .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_ack(tbl_wr_ack), .tbl_rd_ack(tbl_rd_ack)
  );

  typedef struct { logic wr; logic [4:0] addr; logic [127:0] data; } strb_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
  strb_t      sq[$];
  rsp_t       rq[$];
  logic [1:0] bq[$];

  int errors = 0, checks = 0, cyc = 0, strobe_cyc = 0;
  logic ack_en, force_rd_ack, wr_ack_q = 1'b0, rd_ack_q = 1'b0;
  logic [127:0] wd;

  localparam logic [31:0] A_WR0 = 32'h00, A_RD0 = 32'h10, A_RD1 = 32'h14, A_RD2 = 32'h18,
                          A_RD3 = 32'h1C, A_ADDR = 32'h20, A_CMD = 32'h24, A_STAT = 32'h28;

  function automatic logic [127:0] entry_of(input logic [4:0] a);
    return {32'hDEADBEEF, {27'd0, a}, 32'hA5A5_0000, 32'h0BAD_F00D};
  endfunction

  // Table model: registered ack one cycle after each strobe, data from a fixed pattern.
  always @(posedge AXI_ACLK) begin
    cyc      <= cyc + 1;
    wr_ack_q <= ack_en && tbl_wr_req;
    rd_ack_q <= ack_en && tbl_rd_req;
    if (tbl_rd_req) tbl_rd_data <= entry_of(tbl_rd_addr);
  end
  assign tbl_wr_ack = wr_ack_q;
  assign tbl_rd_ack = rd_ack_q | force_rd_ack;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check(tag, 128'(obs), 128'(exp));
  endtask

  always @(negedge AXI_ACLK) begin
    if (tbl_wr_req || tbl_rd_req) begin
      strobe_cyc = cyc;
      if (sq.size() == 0) begin
        check32("unexpected_strobe", 32'({tbl_wr_req, tbl_rd_req}), 32'h0);
      end else begin
        strb_t e;
        e = sq.pop_front();
        check32("strobe_kind", 32'({tbl_wr_req, tbl_rd_req}), e.wr ? 32'h2 : 32'h1);
        check32("strobe_rd_addr", 32'(tbl_rd_addr), 32'(e.addr));
        check32("strobe_wr_addr", 32'(tbl_wr_addr), 32'(e.addr));
        if (e.wr) check("strobe_wr_data", tbl_wr_data, e.data);
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er,
                           input string tag);
    int n;
    bq.push_back(er);
    @(posedge AXI_ACLK); #1;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    check32({tag, " awready"}, 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h3);
    @(posedge AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    do begin @(negedge AXI_ACLK); n++; end while (!S_AXI_BVALID && n < 20);
    check32({tag, " bvalid"}, 32'(S_AXI_BVALID), 32'h1);
    check32({tag, " bresp"}, 32'(S_AXI_BRESP), 32'(bq.pop_front()));
    @(posedge AXI_ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  // target >= 0 raises ARVALID in that cycle, so the register snapshot is taken one cycle later.
  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string tag, input int target = -1);
    int n;
    rq.push_back('{ed, er});
    @(posedge AXI_ACLK); #1;
    if (target >= 0) begin
      n = 0;
      while (cyc < target && n < 500) begin @(posedge AXI_ACLK); #1; n++; end
      check32({tag, " slot"}, 32'(cyc), 32'(target));
    end
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    check32({tag, " arready"}, 32'(S_AXI_ARREADY), 32'h1);
    @(posedge AXI_ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge AXI_ACLK); n++; end while (!S_AXI_RVALID && n < 20);
    check32({tag, " rvalid"}, 32'(S_AXI_RVALID), 32'h1);
    begin
      rsp_t e;
      e = rq.pop_front();
      check32({tag, " rdata"}, S_AXI_RDATA, e.data);
      check32({tag, " rresp"}, 32'(S_AXI_RRESP), 32'(e.resp));
    end
    @(posedge AXI_ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    AXI_RESETN = 1'b0; ack_en = 1'b1; force_rd_ack = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    check32("reset_ctrl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                               S_AXI_RVALID, S_AXI_RRESP, tbl_rd_req, tbl_wr_req}), 32'h0);
    check32("reset_rdata", S_AXI_RDATA, 32'h0);
    @(posedge AXI_ACLK); #1; AXI_RESETN = 1'b1;
    axi_read(A_STAT, 32'h0, 2'b00, "reset_status");
    axi_read(A_ADDR, 32'h0, 2'b00, "reset_addr");

    // Write an entry to index 5.
    wd = {32'h0000_0002, 32'h0A00_0001, 32'hFF00_0000, 32'h0A00_0000};
    for (int i = 0; i < 4; i++) axi_write(A_WR0 + 32'(4 * i), wd[32*i +: 32], 2'b00, "wr_data");
    axi_write(A_ADDR, 32'h5, 2'b00, "addr5");
    axi_read(A_WR0 + 32'h8, 32'h0A00_0001, 2'b00, "wr_data2_rb");
    axi_read(A_ADDR, 32'h5, 2'b00, "addr_rb");
    sq.push_back('{1'b1, 5'd5, wd});
    axi_write(A_CMD, 32'h2, 2'b00, "cmd_wr");
    axi_read(A_STAT, 32'h2, 2'b00, "wr_status");

    // Read back index 5, then index 12.
    sq.push_back('{1'b0, 5'd5, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_rd5");
    axi_read(A_STAT, 32'h2, 2'b00, "rd5_status");
    axi_read(A_RD3, 32'hDEAD_BEEF, 2'b00, "rd5_data3");
    axi_read(A_RD0, 32'h0BAD_F00D, 2'b00, "rd5_data0");
    axi_read(A_RD2, 32'h5, 2'b00, "rd5_data2");
    axi_write(A_ADDR, 32'hC, 2'b00, "addr12");
    sq.push_back('{1'b0, 5'd12, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_rd12");
    axi_read(A_RD2, 32'hC, 2'b00, "rd12_data2");
    axi_read(A_RD1, 32'hA5A5_0000, 2'b00, "rd12_data1");

    // No ack: busy one cycle before the timeout edge, then timeout set, RD_DATA kept.
    ack_en = 1'b0;
    sq.push_back('{1'b0, 5'd12, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_to1");
    axi_read(A_STAT, 32'h1, 2'b00, "to_still_busy", strobe_cyc + 15);
    repeat (20) @(posedge AXI_ACLK);
    axi_read(A_STAT, 32'h4, 2'b00, "to_status");
    axi_read(A_RD2, 32'hC, 2'b00, "to_rd_kept");
    sq.push_back('{1'b0, 5'd12, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_to2");
    axi_read(A_STAT, 32'h4, 2'b00, "to_exact_edge", strobe_cyc + 16);

    // Busy protection: writes during the access are refused and issue nothing.
    sq.push_back('{1'b1, 5'd12, wd});
    axi_write(A_CMD, 32'h2, 2'b00, "cmd_busy");
    axi_write(A_ADDR, 32'h9, 2'b10, "busy_addr");
    axi_write(A_WR0, 32'h11, 2'b10, "busy_wr0");
    axi_write(A_CMD, 32'h1, 2'b10, "busy_cmd");
    repeat (20) @(posedge AXI_ACLK);
    axi_read(A_ADDR, 32'hC, 2'b00, "busy_addr_kept");
    axi_read(A_WR0, 32'h0A00_0000, 2'b00, "busy_wr0_kept");
    check32("busy_strobes_left", 32'(sq.size()), 32'h0);

    // Reset while waiting for an ack, then a late ack.
    sq.push_back('{1'b0, 5'd12, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_rst");
    AXI_RESETN = 1'b0;
    @(negedge AXI_ACLK);
    check32("midrst_ctrl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                                S_AXI_RVALID, S_AXI_RRESP, tbl_rd_req, tbl_wr_req}), 32'h0);
    @(posedge AXI_ACLK); #1; AXI_RESETN = 1'b1; force_rd_ack = 1'b1;
    @(posedge AXI_ACLK); #1; force_rd_ack = 1'b0;
    axi_read(A_STAT, 32'h0, 2'b00, "midrst_status");
    axi_read(A_RD3, 32'h0, 2'b00, "midrst_rd3");
    axi_read(A_ADDR, 32'h0, 2'b00, "midrst_addr");

    // Bad commands, unmapped and read-only accesses.
    axi_write(A_CMD, 32'h3, 2'b00, "cmd_both");
    axi_read(A_STAT, 32'h8, 2'b00, "cmd_both_status");
    axi_write(A_CMD, 32'h0, 2'b00, "cmd_none");
    axi_read(A_STAT, 32'h8, 2'b00, "cmd_none_status");
    axi_read(32'h30, 32'h0, 2'b10, "unmapped_rd");
    axi_write(32'h2C, 32'h1, 2'b10, "unmapped_wr");
    axi_write(A_RD0, 32'h1, 2'b10, "ro_rd0_wr");
    axi_write(A_STAT, 32'h1, 2'b10, "ro_stat_wr");
    axi_read(A_CMD, 32'h0, 2'b00, "cmd_reads0");
    check32("bad_cmd_strobes_left", 32'(sq.size()), 32'h0);

    // A good command clears cmd_err.
    ack_en = 1'b1;
    sq.push_back('{1'b0, 5'd0, 128'h0});
    axi_write(A_CMD, 32'h1, 2'b00, "cmd_recover");
    axi_read(A_STAT, 32'h2, 2'b00, "recover_status");
    axi_read(A_RD3, 32'hDEAD_BEEF, 2'b00, "recover_rd3");
    check32("final_strobes_left", 32'(sq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lpm_tbl_access_ctrl.md
# lpm_tbl_access_ctrl

Register-side initiator for the router's 32-entry × 128-bit LPM route table. It exposes an AXI4-Lite slave to the host, stages entry data and commands, and drives the table's one-cycle `tbl_rd_req`/`tbl_wr_req` strobes. It collects `tbl_rd_ack`/`tbl_wr_ack` and returns read data or status to software. It sits between the AXI-Lite interconnect and the output-port-lookup table port.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- C_BASEADDR, 32'h0000_0000, block base address; bits [5:2] of the offset from this base select the register.
- C_HIGHADDR, 32'h0000_003F, last byte address of the block.
- C_ACK_TIMEOUT, 16, number of cycles after a request strobe without an ack before the transaction times out.

Ports:
- AXI_ACLK, in, 1, single clock.
- AXI_RESETN, in, 1, reset; synchronous, active-low.
- S_AXI_AWADDR / AWVALID / AWREADY, in/in/out, 32/1/1, write address channel.
- S_AXI_WDATA / WSTRB / WVALID / WREADY, in/in/in/out, 32/4/1/1, write data channel; WSTRB is ignored and every write is a full-word write.
- S_AXI_BRESP / BVALID / BREADY, out/out/in, 2/1/1, write response channel.
- S_AXI_ARADDR / ARVALID / ARREADY, in/in/out, 32/1/1, read address channel.
- S_AXI_RDATA / RRESP / RVALID / RREADY, out/out/out/in, 32/2/1/1, read data channel.
- tbl_rd_req, out, 1, read strobe to the table.
- tbl_wr_req, out, 1, write strobe to the table.
- tbl_rd_addr, out, 5, table read index.
- tbl_wr_addr, out, 5, table write index.
- tbl_wr_data, out, 128, entry to write, laid out as {oq, next_hop, mask, ip}.
- tbl_rd_data, in, 128, entry returned by the table.
- tbl_wr_ack, in, 1, write acknowledge from the table.
- tbl_rd_ack, in, 1, read acknowledge from the table.

## Operation
Register map (byte offsets from C_BASEADDR):
- 0x00–0x0C: WR_DATA0..3 (RW). Map to tbl_wr_data[31:0] (ip), [63:32] (mask), [95:64] (next_hop), [127:96] (oq).
- 0x10–0x1C: RD_DATA0..3 (RO). Same word split, captured from tbl_rd_data.
- 0x20: ADDR (RW). Bits [4:0] are the table index; upper bits read as 0.
- 0x24: CMD (WO, reads 0). bit0 = read entry, bit1 = write entry.
- 0x28: STATUS (RO). bit0 busy, bit1 done, bit2 timeout, bit3 cmd_err.

Command FSM states: IDLE, REQ, WAIT_ACK.
- IDLE:
  - CMD write with exactly one of bit0/bit1 set: clear done/timeout/cmd_err, set busy, go to REQ.
  - CMD write with both bits set or neither set: set cmd_err, stay in IDLE, no strobe.
- REQ (one cycle):
  - Assert the selected strobe.
  - tbl_rd_addr and tbl_wr_addr both equal ADDR[4:0].
  - Reset the timeout counter. Go to WAIT_ACK.
- WAIT_ACK:
  - Ack matching the issued command: for a read, latch tbl_rd_data into RD_DATA0..3 in the same edge. Set done, clear busy, go to IDLE.
  - Ack for the other command type: ignored.
  - Counter reaches C_ACK_TIMEOUT: set timeout, clear busy, RD_DATA unchanged, go to IDLE.

AXI-Lite rules:
- One transaction per channel outstanding.
- AWREADY and WREADY assert together for one cycle only when AWVALID, WVALID and !BVALID are all high.
- ARREADY asserts for one cycle when ARVALID and !RVALID.
- B and R responses are held until BREADY / RREADY.
- BRESP/RRESP are OKAY, except SLVERR for:
  - unmapped offset (0x2C–0x3F);
  - write to a RO register;
  - write to WR_DATA, ADDR or CMD while busy. The write is discarded.
- Simultaneous read and write in one cycle are both accepted. The read returns the pre-write value.

Reset values:
- All AXI ready/valid outputs 0; BRESP/RRESP 0; RDATA 0.
- tbl_rd_req and tbl_wr_req 0.
- WR_DATA, RD_DATA, ADDR and STATUS 0; FSM in IDLE.

Mid-operation reset:
- The FSM returns to IDLE and the strobes deassert in the same edge.
- A late ack arriving after reset is ignored.

## Timing
- Cycle T: CMD write handshake.
- Cycle T+1: strobe high, exactly one cycle, never two consecutive cycles.
- An ack sampled at T+2 (the table's registered ack) sets done at T+3, where STATUS reads busy=0, done=1.
- Write response: BVALID asserts the cycle after the AW/W handshake.
- Read response: RVALID asserts the cycle after the AR handshake.
- Timeout: with no ack, busy clears C_ACK_TIMEOUT+1 cycles after the strobe cycle.

## Test plan
- Write entry: WR_DATA0..3 = 0x0A000000, 0xFF000000, 0x0A000001, 0x00000002; ADDR=5; CMD=2 → tbl_wr_req high one cycle with tbl_wr_addr=5 and tbl_wr_data=128'h00000002_0A000001_FF000000_0A000000; after the ack, STATUS=0x2.
- Read-back: model table returns 128'hDEADBEEF_… at index 5; ADDR=5; CMD=1 → tbl_rd_req one cycle, RD_DATA3=0xDEADBEEF, STATUS=0x2.
- No ack: CMD=1 with the ack tied low → STATUS=0x4 after 17 cycles; RD_DATA unchanged.
- Busy protection: CMD=2, then a write to ADDR while busy → BRESP=SLVERR (2'b10), ADDR keeps its old value, exactly one tbl_wr_req issued.
- Bad command and address: CMD=3 → STATUS=0x8 and no strobe; read of offset 0x30 → RRESP=SLVERR; AXI_RESETN low during WAIT_ACK → STATUS=0 and all outputs at reset values.
